// File: rtl/md_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// md_sequencer_pkg
// Shared definitions for the multiply/divide sequencer: operation codes,
// ALU operation codes, FSM state encodings and a magnitude helper.
// -----------------------------------------------------------------------------
package md_sequencer_pkg;

   typedef enum logic [1:0] {
      MD_MULT  = 2'b00,
      MD_MULTU = 2'b01,
      MD_DIV   = 2'b10,
      MD_DIVU  = 2'b11
   } mdop_t;

   typedef enum logic [1:0] {
      ALU_ADD = 2'b00,
      ALU_SUB = 2'b01,
      ALU_OR  = 2'b10,
      ALU_SLT = 2'b11
   } alu_op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_CALC = 2'b01,
      ST_FIX  = 2'b10
   } state_t;

   // Wide enough to count 0..32 iterations.
   localparam int CNT_W = 6;

   // Magnitude of a two's-complement value for signed ops; raw value otherwise.
   // 0x8000_0000 maps to itself, which is the correct unsigned magnitude.
   function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
      return (is_signed && v[31]) ? -v : v;
   endfunction

endpackage

// File: rtl/md_sequencer_alu.sv
// -----------------------------------------------------------------------------
// md_sequencer_alu
// 32-bit ALU shared by the sequencer's iteration step.
// Ports:
//   a, b   : operands
//   op     : ALU_ADD / ALU_SUB / ALU_OR / ALU_SLT
//   y      : result
//   carry  : carry out of add; for sub, 1 means no borrow (a >= b unsigned)
// -----------------------------------------------------------------------------
module md_sequencer_alu
   import md_sequencer_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  alu_op_t     op,
   output logic [31:0] y,
   output logic        carry
);

   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned,
      // which would otherwise infer a latch.
      y     = '0;
      carry = 1'b0;
      case (op)
         ALU_ADD: {carry, y} = {1'b0, a} + {1'b0, b};
         ALU_SUB: {carry, y} = {1'b0, a} + {1'b0, ~b} + 33'd1;
         ALU_OR:  y = a | b;
         ALU_SLT: y = {31'b0, ($signed(a) < $signed(b))};
         default: y = '0;
      endcase
   end

endmodule

// File: rtl/md_sequencer.sv
// -----------------------------------------------------------------------------
// md_sequencer
// Iterative 32x32 multiply / 32/32 divide unit with HI/LO result registers.
// One shift-add (mult) or restoring-divide step per clock through a shared ALU.
// Ports:
//   clk, reset     : clock, asynchronous active-high reset
//   start, mdop    : begin mult / multu / div / divu (ignored while busy)
//   A, B           : multiplicand/dividend, multiplier/divisor
//   hi_we, lo_we,
//   wdata          : direct HI/LO writes, accepted only in IDLE without start
//   busy           : operation in progress
//   done           : one-cycle pulse when HI/LO take a new result
//   hi, lo         : result registers
// -----------------------------------------------------------------------------
module md_sequencer
   import md_sequencer_pkg::*;
#(
   parameter int          ITERS   = 32,
   parameter logic [31:0] DIV0_LO = 32'hFFFF_FFFF
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  mdop,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        hi_we,
   input  logic        lo_we,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   state_t             state, state_next;
   logic               accept, iter_en, finish;
   logic [CNT_W-1:0]   count;

   // Working registers: acc_hi is product-high / partial remainder,
   // acc_lo is multiplier-then-product-low / dividend-then-quotient.
   logic [31:0]        acc_hi, acc_lo, mcand;
   logic               div_op, neg_q, neg_r, div0;
   logic               start_signed;

   alu_op_t            alu_op;
   logic [31:0]        alu_a, alu_b, alu_y;
   logic               alu_c, div_ok;

   logic [63:0]        prod_fix;
   logic [31:0]        quot_fix, rem_fix;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (reset) state <= ST_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      accept     = 1'b0;
      iter_en    = 1'b0;
      finish     = 1'b0;
      case (state)
         ST_IDLE: if (start) begin
            accept     = 1'b1;
            state_next = ST_CALC;
         end
         ST_CALC: begin
            iter_en = 1'b1;
            if (count == CNT_W'(ITERS - 1)) state_next = ST_FIX;
         end
         ST_FIX: begin
            finish     = 1'b1;
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------- ALU step
   md_sequencer_alu u_alu (
      .a     (alu_a),
      .b     (alu_b),
      .op    (alu_op),
      .y     (alu_y),
      .carry (alu_c)
   );

   always_comb begin
      if (div_op) begin
         // Trial subtract of the divisor from {remainder, next dividend bit}.
         // The shifted value is 33 bits; its top bit lives in acc_hi[31].
         alu_op = ALU_SUB;
         alu_a  = {acc_hi[30:0], acc_lo[31]};
         alu_b  = mcand;
      end else begin
         alu_op = ALU_ADD;
         alu_a  = acc_hi;
         alu_b  = acc_lo[0] ? mcand : '0;
      end
   end

   // Subtraction is non-negative if the 33-bit shifted value carried a top bit
   // or the 32-bit subtract produced no borrow; otherwise restore.
   assign div_ok = acc_hi[31] | alu_c;

   assign start_signed = ~mdop[0];

   // ---------------------------------------------------------------- sign fix
   assign prod_fix = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
   assign quot_fix = neg_q ? -acc_lo : acc_lo;
   assign rem_fix  = neg_r ? -acc_hi : acc_hi;

   // ---------------------------------------------------------------- datapath
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count  <= '0;
         acc_hi <= '0;
         acc_lo <= '0;
         mcand  <= '0;
         div_op <= 1'b0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         div0   <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
         hi     <= '0;
         lo     <= '0;
      end else begin
         done <= 1'b0;
         if (accept) begin
            div_op <= mdop[1];
            acc_hi <= '0;
            acc_lo <= abs32(A, start_signed);
            mcand  <= abs32(B, start_signed);
            neg_q  <= start_signed & (A[31] ^ B[31]);
            neg_r  <= start_signed & A[31];
            div0   <= mdop[1] & (B == '0);
            count  <= '0;
            busy   <= 1'b1;
         end else if (iter_en) begin
            count <= count + CNT_W'(1);
            if (div_op) begin
               acc_hi <= div_ok ? alu_y : alu_a;
               acc_lo <= {acc_lo[30:0], div_ok};
            end else begin
               // Add into the upper half, then shift the 65-bit accumulator right.
               acc_hi <= {alu_c, alu_y[31:1]};
               acc_lo <= {alu_y[0], acc_lo[31:1]};
            end
         end else if (finish) begin
            busy <= 1'b0;
            done <= 1'b1;
            if (div_op) begin
               // With a zero divisor the remainder path yields |A|, and the
               // dividend-sign fix restores A exactly.
               hi <= rem_fix;
               lo <= div0 ? DIV0_LO : quot_fix;
            end else begin
               {hi, lo} <= prod_fix;
            end
         end else if (state == ST_IDLE) begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
         end
      end
   end

endmodule

// File: doc/md_sequencer.md
MD_SEQUENCER -- requirements
Module: md_sequencer

Interface
REQ-001 Parameter ITERS, default 32, number of shift/add-subtract iterations per operation (fixed at 32 for the 32-bit datapath).
REQ-002 Parameter DIV0_LO, default 32'hFFFF_FFFF, LO value written on divide-by-zero.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request to begin the operation selected by mdop.
REQ-006 mdop  input  2  00 mult, 01 multu, 10 div, 11 divu.
REQ-007 A  input  32  multiplicand or dividend.
REQ-008 B  input  32  multiplier or divisor.
REQ-009 hi_we  input  1  mthi: HI <= wdata.
REQ-010 lo_we  input  1  mtlo: LO <= wdata.
REQ-011 wdata  input  32  write data for hi_we/lo_we.
REQ-012 busy  output  1  high while an operation is in progress.
REQ-013 done  output  1  one-cycle pulse when HI/LO take a new result.
REQ-014 hi  output  32  HI register.
REQ-015 lo  output  32  LO register.

Function
REQ-016 States: IDLE, CALC, FIX; encoding is local to the block.
REQ-017 In IDLE, start=1 at an edge latches mdop, |A| and |B| (raw values for unsigned ops), records the result signs, clears the iteration counter and enters CALC.
REQ-018 CALC runs for exactly ITERS edges, one iteration per edge, then enters FIX.
REQ-019 mult/multu: shift-add into a 64-bit accumulator; add performed by the ALU adder path (op add).
REQ-020 div/divu: restoring division; trial subtract by the ALU subtract path (op sub); restore on negative.
REQ-021 FIX: one edge applies sign correction, writes HI/LO, asserts done for the following cycle and returns to IDLE.
REQ-022 Signed product is negated when the operand signs differ; signed quotient is negated when the signs differ; remainder takes the dividend's sign.
REQ-023 Latency: start sampled at edge T -> busy=1 from T through T+33 (CALC plus FIX); hi/lo valid and done=1 in the cycle after edge T+33; busy=0 in that same cycle.
REQ-024 done is also asserted for one cycle after a divide-by-zero completes.
REQ-025 busy is a registered output: it rises in the cycle after start is sampled and falls in the same cycle that done rises.
REQ-026 start while busy=1 is ignored; no queuing.
REQ-027 hi_we/lo_we while busy=1 are ignored; in IDLE they write on the edge, and lo_we has no effect on HI.
REQ-028 start and hi_we/lo_we in the same IDLE cycle: start wins and the write is dropped.
REQ-029 Divide by zero (B=0, div or divu): still takes the full latency; HI <= A, LO <= DIV0_LO.
REQ-030 div 0x8000_0000 / -1: LO = 0x8000_0000, HI = 0 (wraps, no trap).
REQ-031 hi/lo hold their values between operations; they change only at FIX or on an accepted hi_we/lo_we.

Reset
REQ-032 Asynchronous reset forces IDLE and sets busy=0, done=0, hi=0, lo=0 and the counter to 0.
REQ-033 Reset mid-operation aborts the operation; no partial result reaches hi/lo.

Structure
REQ-034 A shared package holds the mdop codes (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU), the ALU op codes (add 00, sub 01, or 10, slt 11) and the state encodings.
REQ-035 One sub-module is instantiated: the existing 32-bit ALU, used with ALUOp add/sub for the iteration step; no other arithmetic instances.
REQ-036 Total RTL is 120-400 lines.

Verification
REQ-037 mult A=7, B=-3 -> after 34 cycles hi=0xFFFF_FFFF, lo=0xFFFF_FFEB, one done pulse.
REQ-038 multu A=B=0xFFFF_FFFF -> hi=0xFFFF_FFFE, lo=0x0000_0001.
REQ-039 div A=-7, B=2 -> lo=0xFFFF_FFFD, hi=0xFFFF_FFFF; divu A=0xFFFF_FFFF, B=0x10 -> lo=0x0FFF_FFFF, hi=0xF.
REQ-040 divu A=5, B=0 -> hi=5, lo=DIV0_LO, busy for 33 cycles.
REQ-041 start or hi_we pulsed during busy -> ignored, and the original result is unchanged; hi_we in IDLE with wdata=0x1234 -> hi=0x1234 next cycle.
REQ-042 reset asserted at CALC iteration 10 -> busy=0, hi=lo=0 immediately; a new start after reset completes normally.
